fb_scanout_reader: RTL

- Read side of the double-buffered framebuffer that the depth-tested write path fills.
- Generates framebuffer read addresses from the video timing counters and upscales the low-resolution buffer by 2^SCALE_SHIFT in each axis.
- Aligns the video sync and active signals to the framebuffer read latency.
- Owns the front/back bank selection, and swaps banks only during vertical blanking on request from the renderer.

---
 rtl/fb_pkg.sv | 13 +
 rtl/signal_delay.sv | 23 ++
 rtl/fb_scanout_reader.sv | 117 +++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry and scanout state shared by the read and write paths.
package fb_pkg;
    localparam int FB_WIDTH      = 320;
    localparam int FB_HEIGHT     = 180;
    localparam int FB_BIT_WIDTH  = 16;
    localparam int FB_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        UNSYNCED,
        DISPLAY,
        SWAP_PENDING
    } scan_state_e;
endpackage

// File: rtl/signal_delay.sv
// Fixed-depth shift register with synchronous clear.
module signal_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    logic [DEPTH-1:0][WIDTH-1:0] dly_pipe;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dly_pipe <= '0;
        end else begin
            dly_pipe[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) dly_pipe[i] <= dly_pipe[i-1];
        end
    end

    assign data_out = dly_pipe[DEPTH-1];
endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: upscaled read addressing, latency-matched video timing,
// and front/back bank ownership with vblank-only swaps.
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int FB_BIT_WIDTH  = fb_pkg::FB_BIT_WIDTH,
    parameter int FB_ADDR_WIDTH = fb_pkg::FB_ADDR_WIDTH,
    parameter int FB_WIDTH      = fb_pkg::FB_WIDTH,
    parameter int SCALE_SHIFT   = 2,
    parameter int READ_LATENCY  = 2,
    parameter int V_ACTIVE      = 720
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [10:0]              hcount_in,
    input  logic [9:0]               vcount_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     active_in,
    input  logic                     swap_req_in,
    input  logic [FB_BIT_WIDTH-1:0]  fb_data_in,
    output logic                     fb_re_out,
    output logic [FB_ADDR_WIDTH-1:0] fb_read_addr_out,
    output logic                     fb_front_out,
    output logic                     swap_done_out,
    output logic [FB_BIT_WIDTH-1:0]  pixel_out,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     active_out
);
    localparam int               LAT     = 1 + READ_LATENCY;
    localparam logic [10:0]      FB_W_H  = 11'(FB_WIDTH);
    localparam logic [FB_ADDR_WIDTH-1:0] FB_W_A = FB_ADDR_WIDTH'(FB_WIDTH);
    localparam logic [9:0]       V_ACT_V = 10'(V_ACTIVE);
    localparam logic [9:0]       V_MASK  = 10'((1 << SCALE_SHIFT) - 1);

    logic [10:0]              fb_col;
    logic                     issue;
    logic [FB_ADDR_WIDTH-1:0] row_base, row_base_nxt, line_base;
    logic                     range_d;
    logic                     swap_pt, do_swap, armed;
    scan_state_e              state, state_nxt;

    assign fb_col = hcount_in >> SCALE_SHIFT;
    assign issue  = active_in && (fb_col < FB_W_H);

    // The row base for a line that starts this cycle is taken from the
    // update value so the first pixels of each new source row are correct.
    always_comb begin
        row_base_nxt = row_base;
        if (vcount_in == '0)
            row_base_nxt = '0;
        else if ((vcount_in & V_MASK) == '0 && vcount_in < V_ACT_V)
            row_base_nxt = row_base + FB_W_A;
        line_base = (hcount_in == '0) ? row_base_nxt : row_base;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row_base         <= '0;
            fb_re_out        <= 1'b0;
            fb_read_addr_out <= '0;
        end else begin
            if (hcount_in == '0) row_base <= row_base_nxt;
            fb_re_out <= issue;
            if (issue) fb_read_addr_out <= line_base + FB_ADDR_WIDTH'(fb_col);
        end
    end

    signal_delay #(.WIDTH(4), .DEPTH(LAT)) u_timing_dly (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  ({hsync_in, vsync_in, active_in, issue}),
        .data_out ({hsync_out, vsync_out, active_out, range_d})
    );

    assign pixel_out = (range_d && active_out && state != UNSYNCED) ? fb_data_in : '0;

    assign swap_pt = (hcount_in == '0) && (vcount_in == V_ACT_V);

    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        case (state)
            UNSYNCED: if (hcount_in == '0 && vcount_in == '0) state_nxt = DISPLAY;
            DISPLAY: begin
                if (swap_req_in && armed) begin
                    if (swap_pt) do_swap = 1'b1;
                    else         state_nxt = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (swap_pt) begin
                    do_swap   = 1'b1;
                    state_nxt = DISPLAY;
                end
            end
            default: state_nxt = UNSYNCED;
        endcase
    end

    // armed blocks a still-held request from triggering a second swap
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= UNSYNCED;
            fb_front_out  <= 1'b0;
            swap_done_out <= 1'b0;
            armed         <= 1'b1;
        end else begin
            state         <= state_nxt;
            swap_done_out <= do_swap;
            if (do_swap) fb_front_out <= ~fb_front_out;
            if (do_swap)           armed <= 1'b0;
            else if (!swap_req_in) armed <= 1'b1;
        end
    end
endmodule
